// File: rtl/gray_pkg.sv
// Gray-code helpers and synchronizer depth shared by both sides of the pointer crossing.
package gray_pkg;

    localparam int GRAY_SYNC_STAGES = 2;

    // Callers zero-extend into word_t and truncate back to their own pointer width.
    typedef logic [31:0] word_t;

    function automatic word_t bin2gray(input word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic word_t gray2bin(input word_t g);
        word_t b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop synchronizer for a gray-coded pointer; also used by the read side.
module sync_2ff
    import gray_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         wclk,
    input  logic         wrst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [GRAY_SYNC_STAGES-1:0][W-1:0] stg;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) stg <= '0;
        else         stg <= {stg[GRAY_SYNC_STAGES-2:0], d};
    end

    assign q = stg[GRAY_SYNC_STAGES-1];

endmodule

// File: rtl/gray_wr_sched.sv
// Write-side scheduler: round-robin grant of two requesters, binary/gray write pointer, full flag.
// Optional almost-full flag enabled with GRAY_WR_SCHED_AFULL_EN.
module gray_wr_sched
    import gray_pkg::*;
#(
    parameter int WIDTH        = 3,
    parameter int AFULL_THRESH = 2
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic [1:0]       req,
    output logic [1:0]       gnt,
    input  logic [WIDTH:0]   rptr_gray,
    output logic [WIDTH-1:0] waddr,
    output logic [WIDTH:0]   wptr,
`ifdef GRAY_WR_SCHED_AFULL_EN
    output logic             walmost_full,
`endif
    output logic             wfull
);

    localparam int PW = WIDTH + 1;

    logic [PW-1:0] bin, bin_next, gray_next, rq2, full_cmp;
    logic          last;   // index of the requester granted most recently
    logic          wr, wfull_next;

    sync_2ff #(.W(PW)) u_rsync (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .d      (rptr_gray),
        .q      (rq2)
    );

    // Gated by reset so the grant drops the moment reset asserts.
    always_comb begin
        gnt = 2'b00;
        if (wrst_n && !wfull) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    assign wr         = |gnt;
    assign bin_next   = bin + PW'(wr);
    assign gray_next  = PW'(bin2gray(word_t'(bin_next)));
    assign full_cmp   = {~rq2[WIDTH:WIDTH-1], rq2[WIDTH-2:0]};
    assign wfull_next = (gray_next == full_cmp);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            bin   <= '0;
            wptr  <= '0;
            wfull <= 1'b0;
            last  <= 1'b1;
        end else begin
            bin   <= bin_next;
            wptr  <= gray_next;
            wfull <= wfull_next;
            if (wr) last <= gnt[1];
        end
    end

    assign waddr = bin[WIDTH-1:0];

`ifdef GRAY_WR_SCHED_AFULL_EN
    logic [PW-1:0] used;
    logic [PW:0]   free;

    assign used = bin_next - PW'(gray2bin(word_t'(rq2)));
    assign free = (PW+1)'(1 << WIDTH) - {1'b0, used};

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) walmost_full <= 1'b0;
        else         walmost_full <= (free <= (PW+1)'(AFULL_THRESH));
    end
`endif

endmodule

// File: tb/tb_gray_wr_sched.sv
// Self-checking bench for gray_wr_sched (WIDTH=3): directed tables plus randomized model check.
module tb_gray_wr_sched;

    localparam int WIDTH = 3;
    localparam int THR   = 2;
    localparam int DEPTH = 1 << WIDTH;
    localparam int MODN  = 2 * DEPTH;

    logic       wclk = 1'b0, wrst_n = 1'b0;
    logic [1:0] req = 2'b00, gnt;
    logic [3:0] rptr_gray = 4'd0, wptr;
    logic [2:0] waddr;
    logic       wfull;
`ifdef GRAY_WR_SCHED_AFULL_EN
    logic       walmost_full;
`endif

    int checks = 0, errors = 0;

    gray_wr_sched #(.WIDTH(WIDTH), .AFULL_THRESH(THR)) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .req          (req),
        .gnt          (gnt),
        .rptr_gray    (rptr_gray),
        .waddr        (waddr),
        .wptr         (wptr),
`ifdef GRAY_WR_SCHED_AFULL_EN
        .walmost_full (walmost_full),
`endif
        .wfull        (wfull)
    );

    always #5 wclk = ~wclk;

    function automatic logic [3:0] g(input int b);
        int m;
        m = b % MODN;
        return 4'(m ^ (m >> 1));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", nm, act, exp);
        end
    endtask

    // Called just after a rising edge; release lands well before the next edge.
    task automatic do_rst();
        wrst_n = 1'b0;
        #2;
        wrst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0] req;
        logic [1:0] egnt;
        logic [3:0] ewptr;
        logic       efull;
        logic       eaf;
    } vec_t;

    vec_t fill[9];

    // reference model state
    int  mw, rbin, rs1, rs2;
    logic mfull, maf, mlast;

    function automatic logic [1:0] mgnt(input logic [1:0] r);
        if (mfull) return 2'b00;
        if (r == 2'b11) return mlast ? 2'b01 : 2'b10;
        return r;
    endfunction

    initial begin
        fill[0] = '{2'b01, 2'b01, 4'h1, 1'b0, 1'b0};
        fill[1] = '{2'b01, 2'b01, 4'h3, 1'b0, 1'b0};
        fill[2] = '{2'b01, 2'b01, 4'h2, 1'b0, 1'b0};
        fill[3] = '{2'b01, 2'b01, 4'h6, 1'b0, 1'b0};
        fill[4] = '{2'b01, 2'b01, 4'h7, 1'b0, 1'b0};
        fill[5] = '{2'b01, 2'b01, 4'h5, 1'b0, 1'b1};
        fill[6] = '{2'b01, 2'b01, 4'h4, 1'b0, 1'b1};
        fill[7] = '{2'b01, 2'b01, 4'hC, 1'b1, 1'b1};
        fill[8] = '{2'b01, 2'b00, 4'hC, 1'b1, 1'b1};

        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_wptr", wptr, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wfull", wfull, 0);
        @(posedge wclk); #1;
        wrst_n = 1'b1;

        // fill from empty
        for (int i = 0; i < 9; i++) begin
            req = fill[i].req;
            @(negedge wclk);
            chk($sformatf("fill_gnt%0d", i), gnt, fill[i].egnt);
            @(posedge wclk); #1;
            chk($sformatf("fill_wptr%0d", i), wptr, fill[i].ewptr);
            chk($sformatf("fill_wfull%0d", i), wfull, fill[i].efull);
`ifdef GRAY_WR_SCHED_AFULL_EN
            chk($sformatf("fill_af%0d", i), walmost_full, fill[i].eaf);
`endif
        end

        // release one entry: wfull drops on the 3rd edge, one more grant refills
        rptr_gray = 4'b0001;
        for (int e = 1; e <= 3; e++) begin
            @(negedge wclk);
            chk($sformatf("rel_gnt%0d", e), gnt, 0);
            @(posedge wclk); #1;
            chk($sformatf("rel_wfull%0d", e), wfull, (e < 3) ? 1 : 0);
        end
        @(negedge wclk);
        chk("rel_gnt_one", gnt, 2'b01);
        @(posedge wclk); #1;
        chk("rel_refull", wfull, 1);
        chk("rel_wptr", wptr, 4'hD);
        @(negedge wclk);
        chk("rel_gnt_stop", gnt, 0);

        // arbitration
        @(posedge wclk); #1;
        rptr_gray = 4'd0;
        do_rst();
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge wclk);
            chk($sformatf("arb_both%0d", i), gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
            @(posedge wclk); #1;
        end
        req = 2'b10;
        for (int i = 0; i < 2; i++) begin
            @(negedge wclk);
            chk($sformatf("arb_r1_%0d", i), gnt, 2'b10);
            @(posedge wclk); #1;
        end

        // mid-run asynchronous reset with both requesting
        req = 2'b11;
        wrst_n = 1'b0;
        #1;
        chk("mrst_gnt", gnt, 0);
        chk("mrst_wptr", wptr, 0);
        chk("mrst_waddr", waddr, 0);
        chk("mrst_wfull", wfull, 0);
        @(posedge wclk); #1;
        wrst_n = 1'b1;
        @(negedge wclk);
        chk("mrst_first_gnt", gnt, 2'b01);

        // wrap with reads keeping pace
        @(posedge wclk); #1;
        do_rst();
        req = 2'b01;
        for (int i = 0; i < 20; i++) begin
            @(negedge wclk);
            chk($sformatf("wrap_gnt%0d", i), gnt, 2'b01);
            @(posedge wclk); #1;
            chk($sformatf("wrap_wptr%0d", i), wptr, g(i + 1));
            chk($sformatf("wrap_waddr%0d", i), waddr, (i + 1) % DEPTH);
            chk($sformatf("wrap_wfull%0d", i), wfull, 0);
            rptr_gray = g(i + 1);
        end

        // randomized run against the occupancy model
        req = 2'b00;
        rptr_gray = 4'd0;
        do_rst();
        mw = 0; rbin = 0; rs1 = 0; rs2 = 0;
        mfull = 1'b0; maf = 1'b0; mlast = 1'b1;
        for (int c = 0; c < 600; c++) begin
            logic [1:0] eg;
            int used;
            req = 2'($urandom_range(0, 3));
            if (rbin != mw && $urandom_range(0, 2) == 0) rbin = (rbin + 1) % MODN;
            rptr_gray = g(rbin);
            @(negedge wclk);
            eg = mgnt(req);
            chk("rnd_gnt", gnt, eg);
            chk("rnd_wptr", wptr, g(mw));
            chk("rnd_waddr", waddr, mw % DEPTH);
            chk("rnd_wfull", wfull, mfull);
`ifdef GRAY_WR_SCHED_AFULL_EN
            chk("rnd_af", walmost_full, maf);
`endif
            @(posedge wclk);
            if (eg != 2'b00) begin
                mw = (mw + 1) % MODN;
                mlast = (eg == 2'b10);
            end
            used = (mw - rs2 + MODN) % MODN;
            mfull = (used == DEPTH);
            maf = ((DEPTH - used) <= THR);
            rs2 = rs1;
            rs1 = rbin;
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
